uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for the 12 MHz icestick fabric. It matches the existing transmit path: 8N1 framing, LSB first, idle-high line, 115200 baud by default. Oversamples the asynchronous rx pin with the system clock, samples each bit at mid-period and presents each received byte with a one-cycle valid strobe. Sits between the FTDI/pin rx input and the downstream command/byte consumer.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
CLKS_PER_BIT, CLK_HZ/BAUD (=104), clocks per bit period (localparam, derived)
HALF_BIT, CLKS_PER_BIT/2 (=52), clocks from start-edge detect to start-bit mid-point (localparam, derived)

Ports:
clk  input  1  system clock, 12 MHz
rst  input  1  asynchronous, active-high reset
rx  input  1  raw serial line, asynchronous to clk, idle high
rx_byte  output  8  last correctly received byte; held until next good frame
rx_valid  output  1  one-cycle pulse: rx_byte updated this cycle
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_busy  output  1  high from start-edge detect until return to S_IDLE

Behaviour:
- Reset (async assert, deasserts sync to clk): state=S_IDLE, counter=0, bit index=0, rx_byte=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0, both synchronizer flops=1 (idle-high; no false start out of reset).
- Input conditioning: 2-flop synchronizer on rx gives rx_s. All decisions use rx_s only. Fixed 2-cycle latency from pin.
- Counter width: $clog2(CLKS_PER_BIT)+1 bits; never compared with >=; exact equality on CLKS_PER_BIT-1 / HALF_BIT-1.
- FSM states: S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH.
- S_IDLE: counter=0, rx_busy=0. rx_s==0 -> S_START, counter cleared.
- S_START: count to HALF_BIT-1, then sample rx_s. If rx_s==1 (glitch), go to S_IDLE with no strobe. Else counter=0, bit index=0 -> S_DATA.
- S_DATA: at counter==CLKS_PER_BIT-1, sample rx_s into shift register bit [index], LSB first. Clear counter, increment index. After index 7 is sampled -> S_STOP.
- S_STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: rx_byte<=shift register, rx_valid=1 for exactly that cycle, -> S_IDLE.
  - rx_s==0: rx_frame_err=1 for one cycle, rx_byte unchanged, -> S_WAIT_HIGH.
- S_WAIT_HIGH (break/garbage): stay until rx_s==1, then -> S_IDLE. Prevents a held-low line from retriggering frames.
- Latency: rx_valid asserts 2 + HALF_BIT + 9*CLKS_PER_BIT clocks (=990 at defaults) after the rx pin falls, ±1 cycle of sync phase. This is mid-stop-bit, so the next start edge is accepted immediately; back-to-back frames with 1 stop bit have no gap.
- rx_valid and rx_frame_err are never high in the same cycle. rx_busy=1 in every state except S_IDLE.
- Tolerance: mid-bit sampling accepts sender bit periods within about ±4.5% of CLKS_PER_BIT.
- Reset mid-frame: immediate abort to the reset values above. No strobe, partial byte discarded.
- No receive buffering. The consumer must take rx_byte within one frame time (about 1040 clocks). rx_byte is stable until the next rx_valid.

Decomposition:
- Shared package/include uart_pkg: CLK_HZ, BAUD, CLKS_PER_BIT and the frame constants (DATA_BITS=8, STOP_BITS=1). Used by both the tx and rx blocks so the baud config cannot diverge.
- FSM state encodings stay local.
- One natural sub-module: sync_2ff (parameterised reset value, here 1). It is reusable for other pin inputs (buttons).

Test Plan:
- Drive 8N1 frame 0xA5 at 104 clk/bit -> exactly one rx_valid pulse 990±1 clocks after the falling edge, rx_byte=8'hA5, rx_frame_err never high.
- 20-clock low glitch on idle line -> returns to S_IDLE at start mid-point, no rx_valid/rx_frame_err, rx_busy high about 54 cycles then low.
- Frame 0x3C with stop bit driven low, then line held low 500 clocks, then high -> one rx_frame_err pulse, rx_byte keeps the previous value, no new frame while low, next good frame 0x5A decodes to 8'h5A.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three rx_valid pulses, 1040±1 clocks apart, bytes in order.
- Sender period 100 and 108 clk/bit sending 0x55 -> rx_byte=8'h55 in both cases.
- Assert rst during data bit 4 of frame 0xF0 -> outputs go to reset values asynchronously. After release with the line idle, no strobe. The next frame 0x0F decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART configuration for the tx and rx paths.
// Baud constants and 8N1 frame shape live here so both ends agree.
package uart_pkg;

    localparam int unsigned UART_CLK_HZ = 12000000;
    localparam int unsigned UART_BAUD   = 115200;
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned STOP_BITS   = 1;

    function automatic int unsigned clks_per_bit(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return clk_hz / baud;
    endfunction

    localparam int unsigned UART_CLKS_PER_BIT =
        clks_per_bit(UART_CLK_HZ, UART_BAUD);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs.
// Ports: clk, rst (async high), d_i (raw pin), q_o (synchronized).
// RST_VAL sets both flops on reset so an idle pin never looks active.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling, one-cycle byte strobe.
// Ports: clk, rst (async high), rx (pin), rx_byte, rx_valid,
//        rx_frame_err (stop bit low), rx_busy (frame in progress).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = UART_CLK_HZ,
    parameter int unsigned BAUD   = UART_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [IW-1:0]  idx_q;
    logic [7:0]     shift_q;
    logic [7:0]     byte_q;
    logic           valid_q;
    logic           ferr_q;
    logic           busy_q;
    logic           rx_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q  <= '0;
                    busy_q <= 1'b0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // High at start mid-point means it was a glitch.
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // Hold off until the line idles so a break
                    // cannot retrigger a stream of frames.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_byte      = byte_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, glitch, errors, baud skew, reset.
// Expected values are hand-computed for 104 clk/bit.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int         nvalid = 0;
    int         nerr   = 0;
    int         nboth  = 0;
    int         nbusy  = 0;
    logic [7:0] vq[$];
    int         tq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                nvalid++;
                vq.push_back(rx_byte);
                tq.push_back(cyc);
            end
            if (rx_frame_err) nerr++;
            if (rx_valid && rx_frame_err) nboth++;
            if (rx_busy) nbusy++;
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] in_rng(int v, int lo, int hi);
        return {31'd0, (v >= lo) && (v <= hi)};
    endfunction

    function automatic logic [31:0] vbyte(int i);
        if (i < vq.size()) return {24'd0, vq[i]};
        return 32'hdead;
    endfunction

    function automatic int vtime(int i);
        if (i < tq.size()) return tq[i];
        return -100000;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        nvalid = 0;
        nerr   = 0;
        nbusy  = 0;
        vq.delete();
        tq.delete();
    endtask

    task automatic send_byte(
        input  logic [7:0] b,
        input  int         per,
        input  logic       stop,
        output int         t0
    );
        rx = 1'b0;
        t0 = cyc;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(per);
        end
        rx = stop;
        tick(per);
    endtask

    initial begin
        int t0, t1, t2, td;

        tick(3);
        check("rst_byte",  {24'd0, rx_byte}, 32'h00);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
        check("rst_busy",  {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        tick(10);

        // single good frame and its latency
        clr();
        send_byte(8'hA5, 104, 1'b1, t0);
        tick(60);
        check("a5_count", nvalid, 1);
        check("a5_byte", vbyte(0), 32'hA5);
        check("a5_lat", in_rng(vtime(0) - t0, 989, 991), 1);
        check("a5_ferr", nerr, 0);

        // short low glitch on an idle line
        clr();
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(200);
        check("gl_valid", nvalid, 0);
        check("gl_ferr", nerr, 0);
        check("gl_busy_len", in_rng(nbusy, 50, 56), 1);
        check("gl_busy_end", {31'd0, rx_busy}, 32'd0);

        // stop bit low, then a long break
        clr();
        send_byte(8'h3C, 104, 1'b0, t0);
        tick(500);
        check("br_busy", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        tick(300);
        check("fe_count", nerr, 1);
        check("fe_valid", nvalid, 0);
        check("fe_hold", {24'd0, rx_byte}, 32'hA5);
        send_byte(8'h5A, 104, 1'b1, t0);
        tick(60);
        check("5a_count", nvalid, 1);
        check("5a_byte", vbyte(0), 32'h5A);
        check("5a_ferr", nerr, 1);

        // back-to-back frames, no idle gap
        clr();
        send_byte(8'h00, 104, 1'b1, t0);
        send_byte(8'hFF, 104, 1'b1, t1);
        send_byte(8'h81, 104, 1'b1, t2);
        tick(60);
        check("b2b_count", nvalid, 3);
        check("b2b_b0", vbyte(0), 32'h00);
        check("b2b_b1", vbyte(1), 32'hFF);
        check("b2b_b2", vbyte(2), 32'h81);
        check("b2b_gap1", in_rng(vtime(1) - vtime(0), 1039, 1041), 1);
        check("b2b_gap2", in_rng(vtime(2) - vtime(1), 1039, 1041), 1);

        // sender baud skew
        clr();
        send_byte(8'h55, 100, 1'b1, t0);
        tick(200);
        check("fast_count", nvalid, 1);
        check("fast_byte", vbyte(0), 32'h55);
        clr();
        send_byte(8'h55, 108, 1'b1, t0);
        tick(200);
        check("slow_count", nvalid, 1);
        check("slow_byte", vbyte(0), 32'h55);
        check("slow_ferr", nerr, 0);

        // reset in the middle of data bit 4
        clr();
        fork
            send_byte(8'hF0, 104, 1'b1, td);
            begin
                tick(572);
                check("mid_busy_pre", {31'd0, rx_busy}, 32'd1);
                rst = 1'b1;
                #1;
                check("mid_rst_byte", {24'd0, rx_byte}, 32'h00);
                check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
                check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
            end
        join
        tick(5);
        rst = 1'b0;
        clr();
        tick(1200);
        check("post_rst_valid", nvalid, 0);
        check("post_rst_ferr", nerr, 0);
        send_byte(8'h0F, 104, 1'b1, t0);
        tick(60);
        check("0f_count", nvalid, 1);
        check("0f_byte", vbyte(0), 32'h0F);

        check("never_both", nboth, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
